// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock parametrised FIFO with programmable
// almost-full/almost-empty thresholds, occupancy count, optional
// first-word-fall-through read mode and sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    localparam int              DEPTH    = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic [ADDRSIZE:0] wptr_next;
    logic [ADDRSIZE:0] rptr_next;
    logic [ADDRSIZE:0] count_next;
    logic              wacc;
    logic              racc;

    // Accept decisions use the registered (pre-edge) flags; the pointer
    // difference modulo 2**(ADDRSIZE+1) gives the next occupancy 0..DEPTH.
    always_comb begin
        wacc       = winc & ~wfull;
        racc       = rinc & ~rempty;
        wptr_next  = wptr + {{ADDRSIZE{1'b0}}, wacc};
        rptr_next  = rptr + {{ADDRSIZE{1'b0}}, racc};
        count_next = wptr_next - rptr_next;
    end

    // Pointers, occupancy and all status flags, registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= (AFULL_C == '0);
            ralmost_empty <= 1'b1;
        end else begin
            wptr          <= wptr_next;
            rptr          <= rptr_next;
            count         <= count_next;
            wfull         <= (count_next == DEPTH_C);
            rempty        <= (count_next == '0);
            walmost_full  <= (count_next >= AFULL_C);
            ralmost_empty <= (count_next <= AEMPTY_C);
        end
    end

    // Sticky error flags; a new error event in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (rinc && rempty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    // Storage array; not cleared by reset, written only on an accepted write.
    always_ff @(posedge clk) begin
        if (!rst && wacc)
            mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown continuously; forced to zero while empty.
            assign rdata = rempty ? '0 : mem[rptr[ADDRSIZE-1:0]];
        end else begin : g_std
            logic [DATASIZE-1:0] rdata_q;

            // Registered read: the popped word appears the cycle after rinc.
            always_ff @(posedge clk) begin
                if (rst)
                    rdata_q <= '0;
                else if (racc)
                    rdata_q <= mem[rptr[ADDRSIZE-1:0]];
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a standard-read and an FWFT instance of
// sync_fifo_flex with identical stimulus and checks both against a
// queue-based reference model of the FIFO.
module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] rdata0, rdata1;
    logic          wfull0, wfull1, rempty0, rempty1;
    logic          waf0, waf1, rae0, rae1;
    logic [AW:0]   count0, count1;
    logic          ovf0, ovf1, unf0, unf1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q [$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_rd0 = '0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(AF),
                     .AEMPTY_THRESH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
        .walmost_full(waf0), .ralmost_empty(rae0), .count(count0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    sync_fifo_flex #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(AF),
                     .AEMPTY_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
        .walmost_full(waf1), .ralmost_empty(rae1), .count(count1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge using pre-edge occupancy.
    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r,
                              input logic c, input logic rs);
        bit full, empty;
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd0 = '0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            if (r && !empty) m_rd0 = q.pop_front();
            if (w && !full)  q.push_back(d);
            if (w && full)   m_ovf = 1'b1;
            else if (c)      m_ovf = 1'b0;
            if (r && empty)  m_unf = 1'b1;
            else if (c)      m_unf = 1'b0;
        end
    endtask

    task automatic check_output();
        int n;
        n = q.size();
        check("count_std",  32'(count0), 32'(n));
        check("count_fwft", 32'(count1), 32'(n));
        check("wfull_std",  32'(wfull0), 32'(n == DEPTH));
        check("wfull_fwft", 32'(wfull1), 32'(n == DEPTH));
        check("rempty_std",  32'(rempty0), 32'(n == 0));
        check("rempty_fwft", 32'(rempty1), 32'(n == 0));
        check("afull_std",  32'(waf0), 32'(n >= AF));
        check("afull_fwft", 32'(waf1), 32'(n >= AF));
        check("aempty_std",  32'(rae0), 32'(n <= AE));
        check("aempty_fwft", 32'(rae1), 32'(n <= AE));
        check("ovf_std",  32'(ovf0), 32'(m_ovf));
        check("ovf_fwft", 32'(ovf1), 32'(m_ovf));
        check("unf_std",  32'(unf0), 32'(m_unf));
        check("unf_fwft", 32'(unf1), 32'(m_unf));
        check("rdata_std", 32'(rdata0), 32'(m_rd0));
        if (n > 0)
            check("rdata_fwft", 32'(rdata1), 32'(q[0]));
    endtask

    task automatic apply_stimulus(input logic w, input logic [DW-1:0] d, input logic r,
                                  input logic c, input logic rs);
        winc    = w;
        wdata   = d;
        rinc    = r;
        clr_err = c;
        rst     = rs;
        @(posedge clk);
        model_edge(w, d, r, c, rs);
        #1;
        winc    = 1'b0;
        rinc    = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b0;
        check_output();
    endtask

    initial begin
        int wp, rp;

        // Reset state
        apply_stimulus(0, '0, 0, 0, 1);

        // Fill with 0x00..0x0F, then drain in order
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, DW'(i), 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, '0, 1, 0, 0);
        apply_stimulus(0, '0, 0, 0, 0);

        // Overflow while full, 0xAA must never be stored
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, DW'($urandom), 0, 0, 0);
        apply_stimulus(1, 8'hAA, 0, 0, 0);
        apply_stimulus(0, '0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, '0, 1, 0, 0);

        // Read+write while empty: underflow, write still accepted
        apply_stimulus(1, 8'h55, 1, 0, 0);
        apply_stimulus(0, '0, 1, 0, 0);
        apply_stimulus(0, '0, 0, 1, 0);

        // Steady-state simultaneous traffic at count=8 across pointer wraps
        for (int i = 0; i < 8; i++) apply_stimulus(1, DW'(8'h80 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) apply_stimulus(1, DW'(i), 1, 0, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, '0, 1, 0, 0);

        // FWFT visibility of a single word written into an empty FIFO
        apply_stimulus(1, 8'h3C, 0, 0, 0);
        apply_stimulus(0, '0, 1, 0, 0);

        // Randomised traffic phases sweeping between full and empty
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin wp = 80; rp = 30; end
                1: begin wp = 30; rp = 80; end
                2: begin wp = 50; rp = 50; end
                default: begin wp = 90; rp = 90; end
            endcase
            for (int i = 0; i < 150; i++)
                apply_stimulus($urandom_range(0, 99) < wp, DW'($urandom),
                               $urandom_range(0, 99) < rp,
                               $urandom_range(0, 99) < 5,
                               $urandom_range(0, 199) == 0);
        end

        // Reset mid-operation with count=10 and active winc/rinc
        apply_stimulus(0, '0, 0, 0, 1);
        for (int i = 0; i < 10; i++) apply_stimulus(1, DW'($urandom), 0, 0, 0);
        apply_stimulus(1, 8'h77, 1, 0, 0);
        apply_stimulus(1, 8'h66, 1, 0, 1);
        apply_stimulus(0, '0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; the synchronous successor to the async FIFO, used where producer and consumer share one clock.
- Generalises width and depth and adds:
  - programmable almost-full and almost-empty flags
  - an occupancy count
  - a first-word-fall-through (FWFT) read mode
  - sticky overflow and underflow error flags with a clear input
- Sits between stream producers and consumers inside one clock domain.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; depth = 2**ADDRSIZE words.
- AFULL_THRESH, 12, walmost_full asserts when count >= AFULL_THRESH. Range 1..2**ADDRSIZE.
- AEMPTY_THRESH, 2, ralmost_empty asserts when count <= AEMPTY_THRESH. Range 0..2**ADDRSIZE-1.
- FWFT, 0. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- winc  in  1  write request.
- wdata  in  DATASIZE  write data, sampled when winc=1.
- rinc  in  1  read request (pop).
- rdata  out  DATASIZE  read data.
- wfull  out  1  FIFO full (count == 2**ADDRSIZE).
- rempty  out  1  FIFO empty (count == 0).
- walmost_full  out  1  count >= AFULL_THRESH.
- ralmost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDRSIZE+1  current occupancy, 0..2**ADDRSIZE.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers and count go to 0; rdata goes to 0.
  - rempty=1, ralmost_empty=1, wfull=0, walmost_full=0 (AFULL_THRESH >= 1), overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset dominates every other input in the same cycle. Reset mid-operation discards all stored data.
- Pointers:
  - wptr and rptr are ADDRSIZE+1 bits wide, binary, and wrap modulo 2**(ADDRSIZE+1).
  - Memory is indexed by the low ADDRSIZE bits.
- Write accept = winc & !wfull. On accept: mem[wptr] <= wdata, wptr += 1.
- Read accept = rinc & !rempty. On accept: rptr += 1.
- Status flags are evaluated on pre-edge state:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Count update: count_next = count + wacc - racc.
  - Simultaneous accepted read and write leaves count unchanged.
- Flags: wfull, rempty, walmost_full and ralmost_empty are registered, derived from count_next, and valid in the cycle after the causing edge. No combinational path from winc/rinc to any flag.
- Read data, FWFT=0:
  - On read accept, rdata <= mem[rptr]; the word is visible the cycle after the rinc edge (1-cycle latency).
  - rdata holds its value when no read is accepted.
- Read data, FWFT=1:
  - rdata = mem[rptr] continuously while rempty=0, so the head word is visible without rinc.
  - rinc pops the head; the next word appears after that edge.
  - Write-to-visible latency from empty is 1 cycle: the write edge updates rempty, and the word is valid in the following cycle.
  - rdata is don't-care while rempty=1.
- Error flags:
  - overflow is set by winc & wfull; underflow is set by rinc & rempty.
  - Both are sticky until clr_err=1 or rst.
  - If clr_err is asserted in the same cycle as a new error event, the set wins.
  - Rejected accesses never modify memory, pointers or count.
- Wrap-around: pointers roll over transparently; full and empty remain correct across any number of wraps.
- Throughput: one write and one read per cycle are sustained indefinitely when 0 < count < depth.

Test Plan:
1. Reset, then with FWFT=0 write 16 words 0x00..0x0F on consecutive cycles. Required: wfull=1 after the 16th edge, count=16, walmost_full=1 from count=12. Then read 16: rdata = 0x00..0x0F, each one cycle after its rinc; rempty=1 after the last read; ralmost_empty=1 once count <= 2.
2. With the FIFO full, assert winc with wdata=0xAA for 1 cycle. Required: overflow=1, count stays 16, and 0xAA never appears on a later read. Pulse clr_err: overflow=0.
3. With the FIFO empty, assert rinc and winc (wdata=0x55) in the same cycle. Required: underflow=1, count=1; the next read returns 0x55.
4. With count=8, hold winc and rinc together for 40 cycles using incrementing data. Required: count stays 8, pointers wrap at least twice, and the read order exactly matches the write order.
5. Build with FWFT=1 and write 0x3C into the empty FIFO. Required: rempty=0 and rdata=0x3C in the next cycle with no rinc; one rinc gives rempty=1.
6. Assert rst while count=10 and winc/rinc are active. Required: the next cycle shows count=0, rempty=1, overflow=0, underflow=0, and ignores that cycle's winc/rinc.
